// File: rtl/synth_pkg.sv
// Shared constants and voice-table types for the synth voice path.
package synth_pkg;
  localparam int NUM_OSCILLATORS = 4;
  localparam int SAMPLE_WIDTH = 16;
  localparam int RATE_WIDTH = 24;
  localparam int AGE_W = $clog2(NUM_OSCILLATORS) + 1;

  typedef logic [6:0] note_t;
  typedef logic [RATE_WIDTH-1:0] rate_t;
  typedef logic [AGE_W-1:0] age_t;

  typedef struct packed {
    logic  gate;
    note_t note;
    age_t  age;
    rate_t rate;
  } voice_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_ON,
    EV_OFF
  } ev_t;

  function automatic age_t age_inc(input age_t a);
    return (a == '1) ? a : age_t'(a + 1'b1);
  endfunction
endpackage

// File: rtl/voice_mixer.sv
// Two-stage gated sum of per-voice samples with fixed 1/N attenuation.
module voice_mixer #(
  parameter int N = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N-1:0]              gate_i,
  input  logic [N*SAMPLE_WIDTH-1:0] samples_i,
  output logic [SAMPLE_WIDTH-1:0]   stream_o
);
  localparam int LW = $clog2(N);
  localparam int AW = SAMPLE_WIDTH + LW;

  logic signed [AW-1:0] sum_d, sum_q;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] shifted;
  logic [SAMPLE_WIDTH-1:0] s;
  logic [SAMPLE_WIDTH-1:0] stream_d, stream_q;

  always_comb begin
    sum_d = '0;
    term = '0;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = samples_i[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      term = gate_i[i] ? {{LW{s[SAMPLE_WIDTH-1]}}, s} : '0;
      sum_d = sum_d + term;
    end
  end

  always_comb begin
    shifted = sum_q >>> LW;
    stream_d = shifted[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      stream_q <= '0;
    end else begin
      sum_q <= sum_d;
      stream_q <= stream_d;
    end
  end

  assign stream_o = stream_q;
endmodule

// File: rtl/voice_allocator.sv
// Note-event voice allocator with oldest-voice stealing, feeding the mixer.
module voice_allocator
  import synth_pkg::*;
(
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  valid_in,
  input  logic                                  note_on_in,
  input  logic [6:0]                            note_in,
  input  logic [RATE_WIDTH-1:0]                 rate_in,
  output logic [NUM_OSCILLATORS-1:0]            is_on_out,
  output logic [NUM_OSCILLATORS*RATE_WIDTH-1:0] rate_out,
  output logic [$clog2(NUM_OSCILLATORS):0]      active_count_out,
  input  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] samples_in,
  output logic [SAMPLE_WIDTH-1:0]               stream_out
);
  localparam int N = NUM_OSCILLATORS;
  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;

  voice_t [N-1:0] v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ev_t ev;

  logic hit, free;
  logic [IW-1:0] hit_idx, free_idx, steal_idx, sel;
  age_t best_age;

  always_comb begin
    ev = EV_NONE;
    if (valid_in && note_on_in && rate_in != '0) ev = EV_ON;
    else if (valid_in && !note_on_in) ev = EV_OFF;
  end

  // Lowest-index wins for all three searches
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    steal_idx = '0;
    best_age = v_q[0].age;
    for (int i = 0; i < N; i++) begin
      if (v_q[i].gate && v_q[i].note == note_in && !hit) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!v_q[i].gate && !free) begin
        free = 1'b1;
        free_idx = IW'(i);
      end
      if (i > 0 && v_q[i].age > best_age) begin
        best_age = v_q[i].age;
        steal_idx = IW'(i);
      end
    end
    sel = hit ? hit_idx : (free ? free_idx : steal_idx);
  end

  always_comb begin
    v_d = v_q;
    unique case (1'b1)
      ev == EV_ON: begin
        for (int i = 0; i < N; i++) begin
          if (IW'(i) == sel) begin
            v_d[i].gate = 1'b1;
            v_d[i].note = note_in;
            v_d[i].rate = rate_in;
            v_d[i].age = '0;
          end else if (v_q[i].gate) begin
            v_d[i].age = age_inc(v_q[i].age);
          end
        end
      end
      ev == EV_OFF: begin
        for (int i = 0; i < N; i++) begin
          if (v_q[i].gate && v_q[i].note == note_in) begin
            v_d[i].gate = 1'b0;
            v_d[i].age = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++)
      cnt_d = cnt_d + {{(CW-1){1'b0}}, v_d[i].gate};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v_q <= '0;
      cnt_q <= '0;
    end else begin
      v_q <= v_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    is_on_out = '0;
    rate_out = '0;
    for (int i = 0; i < N; i++) begin
      is_on_out[i] = v_q[i].gate;
      rate_out[i*RATE_WIDTH +: RATE_WIDTH] = v_q[i].rate;
    end
  end

  assign active_count_out = cnt_q;

  voice_mixer #(
    .N(N),
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_mixer (
    .clk_i(clk_in),
    .rst_i(rst_in),
    .gate_i(is_on_out),
    .samples_i(samples_in),
    .stream_o(stream_out)
  );
endmodule

// File: tb/tb_voice_allocator.sv
// Directed vector bench for voice_allocator allocation and mixing.
module tb_voice_allocator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        on = 1'b0;
  logic [6:0]  note = '0;
  logic [23:0] rate = '0;
  logic [3:0]  is_on;
  logic [95:0] rate_o;
  logic [2:0]  cnt;
  logic [63:0] smp = '0;
  logic [15:0] stream;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  voice_allocator dut (
    .clk_in(clk),
    .rst_in(rst),
    .valid_in(vld),
    .note_on_in(on),
    .note_in(note),
    .rate_in(rate),
    .is_on_out(is_on),
    .rate_out(rate_o),
    .active_count_out(cnt),
    .samples_in(smp),
    .stream_out(stream)
  );

  typedef struct {
    logic        r;
    logic        v;
    logic        o;
    logic [6:0]  nt;
    logic [23:0] rt;
    logic [3:0]  on_e;
    logic [2:0]  cnt_e;
    int          ri;
    logic [23:0] rate_e;
  } vec_t;

  vec_t tv[17];

  task automatic ev(input logic r, input logic v, input logic o,
                    input logic [6:0] nt, input logic [23:0] rt);
    @(negedge clk);
    rst = r;
    vld = v;
    on = o;
    note = nt;
    rate = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
  endtask

  task automatic chk_stream(input string nm, input logic [15:0] e);
    n_vec++;
    if (stream !== e) begin
      n_bad++;
      $display("FAIL %s: stream_out got %h want %h", nm, stream, e);
    end
  endtask

  initial begin
    tv[0]  = '{1, 0, 0,  0,    0, 4'b0000, 0, 0,    0};
    tv[1]  = '{0, 1, 1, 60, 2267, 4'b0001, 1, 0, 2267};
    tv[2]  = '{0, 1, 1, 62, 2000, 4'b0011, 2, 1, 2000};
    tv[3]  = '{0, 1, 1, 64, 1800, 4'b0111, 3, 2, 1800};
    tv[4]  = '{0, 1, 1, 65, 1700, 4'b1111, 4, 3, 1700};
    tv[5]  = '{0, 1, 1, 67, 1514, 4'b1111, 4, 0, 1514};
    tv[6]  = '{0, 1, 0, 62,    0, 4'b1101, 3, 1, 2000};
    tv[7]  = '{0, 1, 1, 64, 1600, 4'b1101, 3, 2, 1600};
    tv[8]  = '{0, 1, 0, 70,    0, 4'b1101, 3, 2, 1600};
    tv[9]  = '{0, 1, 1, 72,    0, 4'b1101, 3, 1, 2000};
    tv[10] = '{0, 1, 1, 74,  900, 4'b1111, 4, 1,  900};
    tv[11] = '{0, 1, 0, 67,    0, 4'b1110, 3, 0, 1514};
    tv[12] = '{1, 0, 0,  0,    0, 4'b0000, 0, 0,    0};
    tv[13] = '{0, 1, 1, 60,  100, 4'b0001, 1, 0,  100};
    tv[14] = '{0, 1, 1, 62,  200, 4'b0011, 2, 1,  200};
    tv[15] = '{0, 1, 0, 60,    0, 4'b0010, 1, 0,  100};
    tv[16] = '{0, 1, 1, 60,  300, 4'b0011, 2, 0,  300};

    for (int k = 0; k < 17; k++) begin
      ev(tv[k].r, tv[k].v, tv[k].o, tv[k].nt, tv[k].rt);
      n_vec++;
      if (is_on !== tv[k].on_e || cnt !== tv[k].cnt_e ||
          rate_o[tv[k].ri*24 +: 24] !== tv[k].rate_e) begin
        n_bad++;
        $display("FAIL vec%0d: is_on=%b cnt=%0d rate[%0d]=%0d want is_on=%b cnt=%0d rate=%0d",
                 k, is_on, cnt, tv[k].ri, rate_o[tv[k].ri*24 +: 24],
                 tv[k].on_e, tv[k].cnt_e, tv[k].rate_e);
      end
    end

    // Mixer: two voices gated, others carry full-scale noise
    ev(1, 0, 0, 0, 0);
    chk_stream("reset", 16'h0000);
    ev(0, 1, 1, 60, 10);
    ev(0, 1, 1, 62, 20);
    idle();
    smp = {16'h7FFF, 16'h7FFF, 16'h2000, 16'h4000};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_stream("mix2", 16'h1800);

    ev(0, 1, 1, 64, 30);
    ev(0, 1, 1, 65, 40);
    idle();
    smp = {4{16'h8000}};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_stream("mix4neg", 16'h8000);

    ev(0, 1, 0, 60, 0);
    ev(0, 1, 0, 62, 0);
    ev(0, 1, 0, 64, 0);
    ev(0, 1, 0, 65, 0);
    idle();
    n_vec++;
    if (is_on !== 4'b0000 || cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL alloff: is_on=%b cnt=%0d want 0000 0", is_on, cnt);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_stream("silent", 16'h0000);

    // Mid-stream reset must flush the mixer pipeline in one edge
    ev(0, 1, 1, 60, 10);
    idle();
    smp = {4{16'h4000}};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_stream("pre_rst", 16'h1000);
    ev(1, 0, 0, 0, 0);
    chk_stream("mid_rst", 16'h0000);
    n_vec++;
    if (is_on !== 4'b0000 || cnt !== 3'd0 || rate_o !== '0) begin
      n_bad++;
      $display("FAIL mid_rst_state: is_on=%b cnt=%0d rate=%h want all 0",
               is_on, cnt, rate_o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice allocator and mixer between the MIDI processor and the oscillator bank.
- Accepts decoded note-on/note-off events and assigns each to one of NUM_OSCILLATORS voices, stealing the oldest voice when all are busy.
- Drives per-oscillator is_on and playback rate.
- Mixes the per-oscillator samples returned by the wave loader into one stream for the I2S transmitter.

Parameters:
- NUM_OSCILLATORS, 4, number of voices; power of two, 2..16.
- SAMPLE_WIDTH, 16, signed two's-complement sample width.
- RATE_WIDTH, 24, width of cycles-between-samples playback rate.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous active-high reset.
- valid_in  input  1  one-cycle strobe; event fields valid.
- note_on_in  input  1  1 = note-on, 0 = note-off.
- note_in  input  7  MIDI note number (data byte 1).
- rate_in  input  RATE_WIDTH  playback rate for note_in; sampled on note-on only.
- is_on_out  output  NUM_OSCILLATORS  per-voice gate.
- rate_out  output  NUM_OSCILLATORS x RATE_WIDTH  per-voice playback rate.
- active_count_out  output  $clog2(NUM_OSCILLATORS)+1  number of gated voices.
- samples_in  input  NUM_OSCILLATORS x SAMPLE_WIDTH  per-voice sample from the wave loader.
- stream_out  output  SAMPLE_WIDTH  mixed output sample.

Behaviour:
- Clock and reset: one clock, clk_in; rst_in is synchronous and active-high.
- Reset values: is_on_out = 0; every rate_out = 0; active_count_out = 0; stream_out = 0; per-voice note register = 0; per-voice age = 0. Reset mid-operation clears everything on the next edge, including in-flight mixer pipeline registers.
- Per-voice state: note[6:0], age[AGE_W-1:0] with AGE_W = $clog2(NUM_OSCILLATORS)+1, gate, rate.
- Event latency: is_on_out, rate_out and active_count_out update on the edge after the valid_in cycle (1 cycle). There is no backpressure. Events on consecutive cycles must each be applied; the allocation search is single-cycle combinational over registered state.
- Note-on, with valid_in & note_on_in & rate_in != 0, resolved in priority order:
  1. Retrigger: a gated voice already holds note_in. Overwrite its rate with rate_in, set its age to 0, and age the other gated voices.
  2. Free voice: take the lowest-index ungated voice. Load note and rate, gate = 1, age = 0, and age the other gated voices.
  3. Steal: take the gated voice with the maximum age (ties go to the lowest index). Reload it as in case 2.
- Aging: increment by 1, saturating at 2^AGE_W-1.
- rate_in == 0 on a note-on: the event is dropped, with no state change.
- Note-off, with valid_in & !note_on_in:
  - Clear gate on every gated voice whose note equals note_in. Leave its rate unchanged so the oscillator holds its index. Set its age to 0.
  - No match: ignore.
  - Ages of the other voices are unchanged.
- active_count_out: registered popcount of the next-state gates.
- Mixer: two-stage pipeline, updated every cycle.
  - Stage 1: each term is samples_in[i] sign-extended to SAMPLE_WIDTH+$clog2(N), or 0 if is_on_out[i] = 0. The terms are summed and registered.
  - Stage 2: stream_out = sum >>> $clog2(N) (arithmetic shift), registered.
  - Total latency from samples_in to stream_out is 2 cycles. Fixed attenuation means no overflow and no clipping logic.
- All voices silent: stream_out = 0 two cycles later.

Decomposition:
- Package synth_pkg holds:
  - SAMPLE_WIDTH, NUM_OSCILLATORS, RATE_WIDTH constants;
  - typedef note_t (logic [6:0]);
  - typedef rate_t (logic [RATE_WIDTH-1:0]);
  - typedef voice_t struct {gate, note, age, rate}.
- Sub-module voice_mixer, parameterised by N and SAMPLE_WIDTH, holds the 2-stage gated sum and shift.
- The allocation FSM and voice table stay in voice_allocator.

Test Plan:
- Allocate: reset; note-on 60 rate 2267 -> after 1 cycle is_on_out = 4'b0001, rate_out[0] = 2267, active_count_out = 1.
- Fill and steal: note-on 60, 62, 64, 65, then 67 (rate 1514) -> voice 0 (oldest) is reloaded with note 67, rate 1514; is_on_out = 4'b1111; count = 4.
- Note-off and retrigger:
  - Note-off 62 -> is_on_out = 4'b1101; rate_out[1] is unchanged.
  - Note-on 64 with a new rate -> voice 2 rate updates and no new voice is allocated.
  - Unknown note-off 70 -> no change.
- Edge events:
  - Note-on with rate 0 -> ignored.
  - Back-to-back valid_in (60 then 62 on adjacent cycles) -> both allocated to voices 0 and 1.
  - rst_in asserted mid-sequence -> all outputs 0 next edge.
- Mixer:
  - Voices 0 and 1 on with samples 16'h4000, 16'h2000, others 16'h7FFF and gated off -> stream_out = 16'h1800 two cycles later.
  - All four on at 16'h8000 -> stream_out = 16'h8000.
  - All gates off -> stream_out = 0.
